controller_mc: RTL

//  Parametrised multicycle control FSM for the albaCore datapath, successor to the fixed controller.

---
 rtl/controller_mc.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/controller_mc.sv
// ---------------------------------------------------------------------------
// controller_mc
// Multicycle control FSM for the albaCore datapath. Sequences
// fetch / decode / execute / writeback, handshakes with memory through
// mem_req/mem_ready (any number of wait states), resolves branches in a
// single execute cycle and parks in a resumable HALT state.
//
// Optional feature (compile-time macro):
//   CTRL_PERF_CNT_EN  - when defined, `retired` is a CNT_W-bit wrapping
//                       counter of retired instructions; when undefined,
//                       `retired` is tied to 0 and no counter flops exist.
//
// Ports:
//   clk            in   rising-edge clock
//   reset          in   asynchronous, active-low reset
//   opcode         in   opcode field from the instruction register
//   zero, neg      in   ALU flags used by BZ / BN
//   mem_ready      in   memory completes the current request this cycle
//   resume         in   leave HALT
//   mem_req        out  memory request, held until mem_ready
//   we_mem         out  memory write strobe (only with mem_req)
//   s_addr         out  0 = PC address, 1 = operand address
//   en_inst        out  load instruction register
//   en_a, en_b     out  load operand registers
//   alu_op         out  ALU function
//   en_f           out  load ALU result register
//   en_mdr         out  load memory data register
//   s_regfile_din  out  0 = ALU result, 1 = MDR
//   we_regfile     out  register-file write
//   s_next_pc      out  0 = PC+1, 1 = branch target
//   en_pc          out  load PC
//   halted         out  FSM is in HALT
//   retired        out  retired-instruction count
// ---------------------------------------------------------------------------
module controller_mc #(
    parameter int OPCODE_W = 4,
    parameter int ALU_OP_W = 3,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                zero,
    input  logic                neg,
    input  logic                mem_ready,
    input  logic                resume,
    output logic                mem_req,
    output logic                we_mem,
    output logic                s_addr,
    output logic                en_inst,
    output logic                en_a,
    output logic                en_b,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                en_f,
    output logic                en_mdr,
    output logic                s_regfile_din,
    output logic                we_regfile,
    output logic                s_next_pc,
    output logic                en_pc,
    output logic                halted,
    output logic [CNT_W-1:0]    retired
);

    typedef enum logic [3:0] {
        S_IFETCH  = 4'd0,
        S_IFETCH2 = 4'd1,
        S_DECODE  = 4'd2,
        S_EX_ALU  = 4'd3,
        S_EX_LD   = 4'd4,
        S_EX_LD2  = 4'd5,
        S_EX_ST   = 4'd6,
        S_EX_BR   = 4'd7,
        S_EX_BZ   = 4'd8,
        S_EX_BN   = 4'd9,
        S_WB_ALU  = 4'd10,
        S_WB_MEM  = 4'd11,
        S_HALT    = 4'd12
    } state_t;

    state_t      state;
    state_t      state_n;
    logic [31:0] op_val;

    // Zero-extended opcode so decode thresholds work for any OPCODE_W.
    assign op_val = 32'(opcode);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IFETCH;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n       = state;
        mem_req       = 1'b0;
        we_mem        = 1'b0;
        s_addr        = 1'b0;
        en_inst       = 1'b0;
        en_a          = 1'b0;
        en_b          = 1'b0;
        alu_op        = '0;
        en_f          = 1'b0;
        en_mdr        = 1'b0;
        s_regfile_din = 1'b0;
        we_regfile    = 1'b0;
        s_next_pc     = 1'b0;
        en_pc         = 1'b0;
        halted        = 1'b0;

        case (state)
            S_IFETCH: begin
                mem_req = 1'b1;
                if (mem_ready) state_n = S_IFETCH2;
            end
            S_IFETCH2: begin
                en_inst = 1'b1;
                state_n = S_DECODE;
            end
            S_DECODE: begin
                en_a = 1'b1;
                en_b = 1'b1;
                if (op_val <= 32'd7)        state_n = S_EX_ALU;
                else if (op_val == 32'd8)   state_n = S_EX_LD;
                else if (op_val == 32'd9)   state_n = S_EX_ST;
                else if (op_val == 32'd10)  state_n = S_EX_BR;
                else if (op_val == 32'd11)  state_n = S_EX_BZ;
                else if (op_val == 32'd12)  state_n = S_EX_BN;
                else                        state_n = S_HALT;
            end
            S_EX_ALU: begin
                alu_op  = opcode[ALU_OP_W-1:0];
                en_f    = 1'b1;
                state_n = S_WB_ALU;
            end
            S_EX_LD: begin
                mem_req = 1'b1;
                s_addr  = 1'b1;
                if (mem_ready) state_n = S_EX_LD2;
            end
            S_EX_LD2: begin
                en_mdr  = 1'b1;
                state_n = S_WB_MEM;
            end
            S_EX_ST: begin
                // The store retires in the same cycle memory accepts it.
                mem_req = 1'b1;
                we_mem  = 1'b1;
                s_addr  = 1'b1;
                if (mem_ready) begin
                    en_pc   = 1'b1;
                    state_n = S_IFETCH;
                end
            end
            S_EX_BR: begin
                en_pc     = 1'b1;
                s_next_pc = 1'b1;
                state_n   = S_IFETCH;
            end
            S_EX_BZ: begin
                en_pc     = 1'b1;
                s_next_pc = zero;
                state_n   = S_IFETCH;
            end
            S_EX_BN: begin
                en_pc     = 1'b1;
                s_next_pc = neg;
                state_n   = S_IFETCH;
            end
            S_WB_ALU: begin
                we_regfile = 1'b1;
                en_pc      = 1'b1;
                state_n    = S_IFETCH;
            end
            S_WB_MEM: begin
                we_regfile    = 1'b1;
                s_regfile_din = 1'b1;
                en_pc         = 1'b1;
                state_n       = S_IFETCH;
            end
            S_HALT: begin
                halted = 1'b1;
                if (resume) begin
                    en_pc   = 1'b1;
                    state_n = S_IFETCH;
                end
            end
            default: begin
                state_n = S_HALT;
            end
        endcase

        // While reset is held the state register already sits in IFETCH,
        // which would otherwise raise mem_req; every output is masked so
        // that nothing reaches memory or the datapath until release.
        if (!reset) begin
            mem_req       = 1'b0;
            we_mem        = 1'b0;
            s_addr        = 1'b0;
            en_inst       = 1'b0;
            en_a          = 1'b0;
            en_b          = 1'b0;
            alu_op        = '0;
            en_f          = 1'b0;
            en_mdr        = 1'b0;
            s_regfile_din = 1'b0;
            we_regfile    = 1'b0;
            s_next_pc     = 1'b0;
            en_pc         = 1'b0;
            halted        = 1'b0;
        end
    end

`ifdef CTRL_PERF_CNT_EN
    // Leaving HALT pulses en_pc but is not an instruction retiring.
    logic             retire;
    logic [CNT_W-1:0] retired_q;

    assign retire = en_pc & (state != S_HALT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            retired_q <= '0;
        end else if (retire) begin
            retired_q <= retired_q + CNT_W'(1);
        end
    end

    assign retired = retired_q;
`else
    assign retired = '0;
`endif

endmodule
